dot_product_stream: RTL and testbench



---
 rtl/dot_product_stream.sv | 152 +++++++++++++++
 tb/tb_dot_product_stream.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_stream.sv
// dot_product_stream: streaming dot product of two LENGTH-element vectors,
// LANES element pairs per accepted beat. A registered multiply stage feeds a
// full-precision accumulator; the finished sum is held on a valid/ready output.
module dot_product_stream #(
  parameter int DATA_W  = 32,
  parameter int LENGTH  = 8,
  parameter int LANES   = 2,
  parameter int SIGNED  = 0,
  localparam int ACC_W  = 2*DATA_W + $clog2(LENGTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_a,
  input  logic [LANES*DATA_W-1:0]   in_b,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          result
);

  localparam int BEATS  = LENGTH / LANES;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PROD_W = 2*DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                        state_r;
  state_t                        state_next_s;
  logic [CNT_W-1:0]              cnt_r;
  logic [LANES-1:0][PROD_W-1:0]  prod_r;
  logic                          prod_vld_r;
  logic [ACC_W-1:0]              acc_r;
  logic [ACC_W-1:0]              lane_sum_s;
  logic                          accept_s;
  logic                          last_s;
  logic                          clear_s;

  // Full-width lane product; operands are extended to the product width first
  // so the low PROD_W bits of the multiply are exact in both signed modes.
  function automatic logic [PROD_W-1:0] mul_lane(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [PROD_W-1:0] ea;
    logic [PROD_W-1:0] eb;
    if (SIGNED != 0) begin
      ea = PROD_W'($signed(a));
      eb = PROD_W'($signed(b));
    end else begin
      ea = PROD_W'(a);
      eb = PROD_W'(b);
    end
    return ea * eb;
  endfunction

  // Widen a lane product to accumulator width (sign- or zero-extension).
  function automatic logic [ACC_W-1:0] ext_prod(input logic [PROD_W-1:0] p);
    logic [ACC_W-1:0] e;
    if (SIGNED != 0) begin
      e = ACC_W'($signed(p));
    end else begin
      e = ACC_W'(p);
    end
    return e;
  endfunction

  // Handshake qualifiers derived from the current state.
  always_comb begin
    accept_s = in_valid && (state_r == RUN);
    last_s   = accept_s && (cnt_r == CNT_W'(BEATS - 1));
    clear_s  = start && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
  end

  // Sum of the registered lane products for the stage-2 add.
  always_comb begin
    lane_sum_s = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum_s = lane_sum_s + ext_prod(prod_r[i]);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (last_s) state_next_s = DRAIN;
        else        state_next_s = RUN;
      end
      DRAIN: begin
        state_next_s = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (start) state_next_s = RUN;
          else       state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // Beat counter, multiply stage and accumulator.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r      <= '0;
      prod_r     <= '0;
      prod_vld_r <= 1'b0;
      acc_r      <= '0;
    end else begin
      if (accept_s) begin
        for (int i = 0; i < LANES; i++) begin
          prod_r[i] <= mul_lane(in_a[i*DATA_W +: DATA_W], in_b[i*DATA_W +: DATA_W]);
        end
      end
      prod_vld_r <= accept_s;
      if (clear_s)         acc_r <= '0;
      else if (prod_vld_r) acc_r <= acc_r + lane_sum_s;
      if (clear_s)         cnt_r <= '0;
      else if (accept_s)   cnt_r <= last_s ? CNT_W'(0) : cnt_r + CNT_W'(1);
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    in_ready  = (state_r == RUN);
    busy      = (state_r == RUN) || (state_r == DRAIN);
    out_valid = (state_r == DONE);
    result    = acc_r;
  end

endmodule

// File: tb/tb_dot_product_stream.sv
// Self-checking bench for dot_product_stream: an unsigned and a signed
// instance share stimulus; a vector table drives the main cases and short
// hand-written sequences cover gaps, backpressure and mid-run reset.
module tb_dot_product_stream;

  localparam int ACC_W = 67;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic               in_valid;
  logic [63:0]        in_a;
  logic [63:0]        in_b;
  logic               out_ready;
  logic               in_ready, busy, out_valid;
  logic [ACC_W-1:0]   result;
  logic               in_ready_s, busy_s, out_valid_s;
  logic [ACC_W-1:0]   result_s;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0][31:0]  a;
    logic [7:0][31:0]  b;
    logic [ACC_W-1:0]  exp_u;
    logic [ACC_W-1:0]  exp_s;
  } vec_t;

  vec_t vecs [6];

  dot_product_stream #(.DATA_W(32), .LENGTH(8), .LANES(2), .SIGNED(0)) u_dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  dot_product_stream #(.DATA_W(32), .LENGTH(8), .LANES(2), .SIGNED(1)) u_dut_s (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready_s), .in_a(in_a), .in_b(in_b), .busy(busy_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .result(result_s)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [ACC_W-1:0] act,
                        input logic [ACC_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered at the negedge after the start edge (state RUN). Feeds vector v,
  // optionally with a gap before beat 2, checks DRAIN and DONE timing and
  // finishes with a handshake unless hold is set.
  task automatic feed(input int v, input int gap_len, input bit hold);
    check1("run_busy", busy, 1'b1);
    check1("run_in_ready", in_ready, 1'b1);
    check1("run_out_valid", out_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        for (int g = 0; g < gap_len; g++) begin
          in_valid = 1'b0;
          tick();
          check1("gap_in_ready", in_ready, 1'b1);
          check1("gap_out_valid", out_valid, 1'b0);
        end
      end
      in_valid = 1'b1;
      in_a = {vecs[v].a[2*k+1], vecs[v].a[2*k]};
      in_b = {vecs[v].b[2*k+1], vecs[v].b[2*k]};
      tick();
    end
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    check1("drain_busy", busy, 1'b1);
    check1("drain_in_ready", in_ready, 1'b0);
    check1("drain_out_valid", out_valid, 1'b0);
    tick();
    check1("done_out_valid", out_valid, 1'b1);
    check1("done_busy", busy, 1'b0);
    checkw("result_unsigned", result, vecs[v].exp_u);
    check1("done_out_valid_signed", out_valid_s, 1'b1);
    checkw("result_signed", result_s, vecs[v].exp_s);
    if (!hold) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check1("idle_out_valid", out_valid, 1'b0);
      check1("idle_busy", busy, 1'b0);
    end
  endtask

  task automatic run_vec(input int v, input int gap_len, input bit hold);
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(v, gap_len, hold);
  endtask

  initial begin
    // Vector table with hand-computed results (ACC_W = 67).
    for (int i = 0; i < 8; i++) begin
      vecs[0].a[i] = 32'(i + 1);       vecs[0].b[i] = 32'd2;
      vecs[1].a[i] = 32'hFFFF_FFFF;    vecs[1].b[i] = 32'hFFFF_FFFF;
      vecs[2].a[i] = 32'hFFFF_FFFF;    vecs[2].b[i] = 32'(i + 1);
      vecs[3].a[i] = 32'd1;            vecs[3].b[i] = 32'd1;
      vecs[4].a[i] = 32'h8000_0000;    vecs[4].b[i] = 32'h8000_0000;
      vecs[5].a[i] = 32'(i + 1);       vecs[5].b[i] = 32'hFFFF_FFFE;
    end
    vecs[0].exp_u = 67'd72;                   vecs[0].exp_s = 67'd72;
    vecs[1].exp_u = 67'h7_FFFF_FFF0_0000_0008; vecs[1].exp_s = 67'd8;
    vecs[2].exp_u = 67'h0_0000_0023_FFFF_FFDC; vecs[2].exp_s = 67'h7_FFFF_FFFF_FFFF_FFDC;
    vecs[3].exp_u = 67'd8;                    vecs[3].exp_s = 67'd8;
    vecs[4].exp_u = 67'h2_0000_0000_0000_0000; vecs[4].exp_s = 67'h2_0000_0000_0000_0000;
    vecs[5].exp_u = 67'h0_0000_0023_FFFF_FFB8; vecs[5].exp_s = 67'h7_FFFF_FFFF_FFFF_FFB8;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    tick();
    tick();
    reset = 1'b0;
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    checkw("rst_result", result, 67'd0);

    // in_valid outside RUN is ignored: stay idle.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check1("idle_ignores_valid", busy, 1'b0);

    // Table-driven main function.
    for (int v = 0; v < 6; v++) begin
      run_vec(v, 0, 1'b0);
    end

    // Three-cycle input gap between beats 1 and 2.
    run_vec(0, 3, 1'b0);

    // Backpressure in DONE with start pulses, then back-to-back restart.
    run_vec(0, 0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      out_ready = 1'b0;
      start = (c % 2 == 0);
      tick();
      check1("bp_out_valid", out_valid, 1'b1);
      check1("bp_busy", busy, 1'b0);
      checkw("bp_result", result, 67'd72);
    end
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    feed(3, 0, 1'b0);

    // Reset after two accepted beats of large operands.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_a = {vecs[1].a[2*k+1], vecs[1].a[2*k]};
      in_b = {vecs[1].b[2*k+1], vecs[1].b[2*k]};
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    check1("mid_rst_in_ready", in_ready, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_out_valid", out_valid, 1'b0);
    checkw("mid_rst_result", result, 67'd0);
    checkw("mid_rst_result_signed", result_s, 67'd0);
    tick();
    check1("mid_rst_stays_idle", busy, 1'b0);
    run_vec(0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
